// File: rtl/seq_alu.sv
// seq_alu: accumulator ALU with single-cycle arithmetic/logic ops, a bit-serial
// shifter and a shift-and-add multiplier.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops and reserved opcodes finish here
// SHIFT | work register shifted one bit per cycle, cnt counts bits left
// MUL   | one multiplier bit consumed per cycle, cnt counts bits left
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_NOT = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_LDB = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_CLR = 4'd4;
    localparam logic [3:0] OP_SBB = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   acc_nxt;
    logic               carry_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic [WIDTH-1:0]   work, work_nxt;
    logic [2*WIDTH-1:0] mcand, mcand_nxt;
    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [2*WIDTH-1:0] prod_add;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               shl, shl_nxt;
    logic [WIDTH:0]     sum;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        carry_nxt = carry;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        work_nxt  = work;
        mcand_nxt = mcand;
        prod_nxt  = prod;
        cnt_nxt   = cnt;
        shl_nxt   = shl;
        sum       = '0;
        prod_add  = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOT: begin
                            acc_nxt  = ~acc;
                            done_nxt = 1'b1;
                        end
                        OP_ADC: begin
                            sum = {1'b0, acc} + {1'b0, b} + {{WIDTH{1'b0}}, carry};
                            {carry_nxt, acc_nxt} = sum;
                            done_nxt = 1'b1;
                        end
                        OP_LDB: begin
                            acc_nxt  = b;
                            done_nxt = 1'b1;
                        end
                        OP_INC: begin
                            sum = {1'b0, acc} + {{WIDTH{1'b0}}, 1'b1};
                            {carry_nxt, acc_nxt} = sum;
                            done_nxt = 1'b1;
                        end
                        OP_CLR: begin
                            acc_nxt   = '0;
                            carry_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end
                        OP_SBB: begin
                            // The wrapped ninth... (WIDTH+1)th bit is the borrow
                            sum = {1'b0, acc} - {1'b0, b} - {{WIDTH{1'b0}}, carry};
                            {carry_nxt, acc_nxt} = sum;
                            done_nxt = 1'b1;
                        end
                        OP_AND: begin
                            acc_nxt  = acc & b;
                            done_nxt = 1'b1;
                        end
                        OP_OR: begin
                            acc_nxt  = acc | b;
                            done_nxt = 1'b1;
                        end
                        OP_XOR: begin
                            acc_nxt  = acc ^ b;
                            done_nxt = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            if (b[SW-1:0] == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt = SHIFT;
                                busy_nxt  = 1'b1;
                                work_nxt  = acc;
                                cnt_nxt   = {1'b0, b[SW-1:0]};
                                shl_nxt   = (op == OP_SHL);
                            end
                        end
                        OP_MUL: begin
                            state_nxt = MUL;
                            busy_nxt  = 1'b1;
                            work_nxt  = b;
                            mcand_nxt = {{WIDTH{1'b0}}, acc};
                            prod_nxt  = '0;
                            cnt_nxt   = CW'(WIDTH);
                        end
                        default: begin
                            err_nxt  = 1'b1;
                            done_nxt = 1'b1;
                        end
                    endcase
                end
            end

            SHIFT: begin
                busy_nxt = 1'b1;
                cnt_nxt  = cnt - CW'(1);
                if (shl) begin
                    work_nxt = {work[WIDTH-2:0], 1'b0};
                end else begin
                    work_nxt = {1'b0, work[WIDTH-1:1]};
                end
                if (cnt == CW'(1)) begin
                    acc_nxt   = work_nxt;
                    carry_nxt = shl ? work[WIDTH-1] : work[0];
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            MUL: begin
                busy_nxt  = 1'b1;
                cnt_nxt   = cnt - CW'(1);
                prod_add  = work[0] ? (prod + mcand) : prod;
                prod_nxt  = prod_add;
                mcand_nxt = {mcand[2*WIDTH-2:0], 1'b0};
                work_nxt  = {1'b0, work[WIDTH-1:1]};
                if (cnt == CW'(1)) begin
                    acc_nxt   = prod_add[WIDTH-1:0];
                    carry_nxt = |prod_add[2*WIDTH-1:WIDTH];
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // zero/neg are derived from the next accumulator so they move with acc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            work  <= '0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            shl   <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            carry <= carry_nxt;
            zero  <= (acc_nxt == '0);
            neg   <= acc_nxt[WIDTH-1];
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            work  <= work_nxt;
            mcand <= mcand_nxt;
            prod  <= prod_nxt;
            cnt   <= cnt_nxt;
            shl   <= shl_nxt;
        end
    end

endmodule
